// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared types and defaults for the tick enable generator
//
// Purpose: FSM state encoding and default parameter values shared by
// tick_enable_gen and step_debounce.
// Ports: none (package).

package tick_gen_pkg;

  // Encodings are fixed so that waveforms and any downstream debug taps
  // read the same on every build.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } tick_state_e;

  localparam int DIV_W_DEF = 8;
  localparam int SYNC_DEF  = 2;
  localparam int DB_DEF    = 4;

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - push-button synchronizer, debouncer and rise detector
//
// Purpose: turns a raw, bouncy, asynchronous push-button into a single
// one-cycle event on each clean press.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   step_btn  in   raw asynchronous push-button level
//   step_evt  out  registered one-cycle pulse on a debounced 0->1 transition

module step_debounce
  import tick_gen_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DB_CYCLES   = DB_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic step_btn,
  output logic step_evt
);

  // The counter has to be able to hold DB_CYCLES itself.
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_prev_q;
  logic                   evt_q, evt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = '0;
    sync_d[0] = step_btn;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // The level only moves after the synced value has disagreed with it for
  // DB_CYCLES cycles and still disagrees; any agreement restarts the count,
  // so short glitches are simply absorbed.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (synced == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES)) begin
      db_d  = synced;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Rise detect is registered so the event is a clean flop output.
  always_comb begin
    evt_d = db_q & ~db_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      evt_q     <= evt_d;
    end
  end

  assign step_evt = evt_q;

endmodule

// File: rtl/tick_enable_gen.sv
// rtl/tick_enable_gen.sv - enable-pulse source for the 2-bit T-flip-flop counter
//
// Purpose: drives the counter's T0 input with free-running pulses at a
// programmable rate (RUN), a single debounced push-button step (STEP), or
// nothing (IDLE).
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   level; IDLE -> RUN when high and stop is low
//   stop      in   level; RUN -> IDLE, also blocks start in IDLE
//   step_btn  in   raw asynchronous push-button
//   div       in   DIV_W; run period minus one, read live
//   T0        out  registered one-cycle enable to the counter
//   running   out  registered; high while in RUN
//   step_ack  out  registered; high with T0 for a step pulse only

module tick_enable_gen
  import tick_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DB_CYCLES   = DB_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step_btn,
  input  logic [DIV_W-1:0] div,
  output logic             T0,
  output logic             running,
  output logic             step_ack
);

  tick_state_e      state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             t0_q, t0_d;
  logic             running_q, running_d;
  logic             ack_q, ack_d;
  logic             step_evt;
  logic             pulse_due;

  step_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .step_btn (step_btn),
    .step_evt (step_evt)
  );

  // >= rather than == so that shrinking div below the current count fires
  // on the next cycle instead of waiting for a wrap.
  assign pulse_due = (presc_q >= div);

  // State, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      t0_q      <= 1'b0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      t0_q      <= t0_d;
      running_q <= running_d;
      ack_q     <= ack_d;
    end
  end

  // Next state and prescaler. Step events arriving outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
        end else if (step_evt) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler only advances while staying in RUN; every other path,
  // including RUN entry and exit, leaves it at zero.
  always_comb begin
    presc_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      presc_d = pulse_due ? '0 : presc_q + DIV_W'(1);
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state. The RUN pulse also requires already
  // being in RUN: the entry edge never pulses, and a stop edge suppresses a
  // pulse that was due.
  always_comb begin
    t0_d      = 1'b0;
    running_d = 1'b0;
    ack_d     = 1'b0;
    unique case (state_d)
      RUN: begin
        running_d = 1'b1;
        t0_d      = (state_q == RUN) && pulse_due;
      end
      STEP: begin
        t0_d  = 1'b1;
        ack_d = 1'b1;
      end
      default: begin
        t0_d = 1'b0;
      end
    endcase
  end

  assign T0       = t0_q;
  assign running  = running_q;
  assign step_ack = ack_q;

endmodule
